// File: rtl/regfile_bypass.sv
// regfile_bypass: register file with byte-enable writes, optional
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module regfile_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    input  logic                    ctrl_writeEn,
    input  logic [ADDR_WIDTH-1:0]   ctrl_writeReg,
    input  logic [DATA_WIDTH/8-1:0] ctrl_byteEn,
    input  logic [DATA_WIDTH-1:0]   data_writeReg,
    input  logic [ADDR_WIDTH-1:0]   ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0]   ctrl_readRegB,
    output logic [DATA_WIDTH-1:0]   data_readRegA,
    output logic [DATA_WIDTH-1:0]   data_readRegB,
    input  logic                    ctrl_setBusy,
    input  logic [ADDR_WIDTH-1:0]   ctrl_busyReg,
    output logic                    busy_readRegA,
    output logic                    busy_readRegB
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busyNext;
    logic [DATA_WIDTH-1:0] byteMask;
    logic [DATA_WIDTH-1:0] writeMerged;
    logic                  writeLegal;
    logic                  setLegal;
    logic                  fwdEn;

    // Legal write/set: index 0 is untouchable when it is the zero register.
    assign writeLegal = ctrl_writeEn
                      && !(ZERO_EN && (ctrl_writeReg == '0));
    assign setLegal   = ctrl_setBusy
                      && !(ZERO_EN && (ctrl_busyReg == '0));
    // Forwarding never happens across a reset edge.
    assign fwdEn      = BYP_EN && writeLegal && !ctrl_reset;

    // Expand the per-byte enables into a bit mask.
    always_comb begin
        byteMask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            byteMask[8*i +: 8] = {8{ctrl_byteEn[i]}};
        end
    end

    // Post-write value of the target register; also the bypass value.
    assign writeMerged = (regs[ctrl_writeReg] & ~byteMask)
                       | (data_writeReg & byteMask);

    // Scoreboard next state: a write clears, a set (issued later) wins.
    always_comb begin
        busyNext = busy;
        if (writeLegal) begin
            busyNext[ctrl_writeReg] = 1'b0;
        end
        if (setLegal) begin
            busyNext[ctrl_busyReg] = 1'b1;
        end
    end

    // Register array and scoreboard update; reset overrides everything.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (writeLegal) begin
                regs[ctrl_writeReg] <= writeMerged;
            end
            busy <= busyNext;
        end
    end

    // Read port A with zero-register masking and optional bypass.
    always_comb begin
        data_readRegA = regs[ctrl_readRegA];
        busy_readRegA = busy[ctrl_readRegA];
        if (ZERO_EN && (ctrl_readRegA == '0)) begin
            data_readRegA = '0;
            busy_readRegA = 1'b0;
        end else if (fwdEn && (ctrl_readRegA == ctrl_writeReg)) begin
            data_readRegA = writeMerged;
            if (!(setLegal && (ctrl_busyReg == ctrl_readRegA))) begin
                busy_readRegA = 1'b0;
            end
        end
    end

    // Read port B, identical to port A.
    always_comb begin
        data_readRegB = regs[ctrl_readRegB];
        busy_readRegB = busy[ctrl_readRegB];
        if (ZERO_EN && (ctrl_readRegB == '0)) begin
            data_readRegB = '0;
            busy_readRegB = 1'b0;
        end else if (fwdEn && (ctrl_readRegB == ctrl_writeReg)) begin
            data_readRegB = writeMerged;
            if (!(setLegal && (ctrl_busyReg == ctrl_readRegB))) begin
                busy_readRegB = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: scoreboard bench for regfile_bypass covering
// bypass/non-bypass builds and a 64-bit, 8-entry build.
module tb_regfile_bypass;
    logic        clock = 1'b0;
    logic        rst;
    logic        wEn;
    logic [4:0]  wReg;
    logic [3:0]  be;
    logic [31:0] wData;
    logic [4:0]  rA, rB;
    logic        setB;
    logic [4:0]  bReg;
    logic [31:0] dA0, dB0, dA1, dB1;
    logic        bA0, bB0, bA1, bB1;

    logic        w2En;
    logic [2:0]  w2Reg;
    logic [7:0]  be2;
    logic [63:0] wData2;
    logic [2:0]  rA2, rB2;
    logic        set2;
    logic [2:0]  bReg2;
    logic [63:0] dA2, dB2;
    logic        bA2, bB2;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } expEntry;
    expEntry sb[$];

    always #5 clock = ~clock;

    regfile_bypass u0 (
        .clock(clock), .ctrl_reset(rst), .ctrl_writeEn(wEn),
        .ctrl_writeReg(wReg), .ctrl_byteEn(be), .data_writeReg(wData),
        .ctrl_readRegA(rA), .ctrl_readRegB(rB),
        .data_readRegA(dA0), .data_readRegB(dB0),
        .ctrl_setBusy(setB), .ctrl_busyReg(bReg),
        .busy_readRegA(bA0), .busy_readRegB(bB0)
    );

    regfile_bypass #(.BYPASS(0)) u1 (
        .clock(clock), .ctrl_reset(rst), .ctrl_writeEn(wEn),
        .ctrl_writeReg(wReg), .ctrl_byteEn(be), .data_writeReg(wData),
        .ctrl_readRegA(rA), .ctrl_readRegB(rB),
        .data_readRegA(dA1), .data_readRegB(dB1),
        .ctrl_setBusy(setB), .ctrl_busyReg(bReg),
        .busy_readRegA(bA1), .busy_readRegB(bB1)
    );

    regfile_bypass #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) u2 (
        .clock(clock), .ctrl_reset(rst), .ctrl_writeEn(w2En),
        .ctrl_writeReg(w2Reg), .ctrl_byteEn(be2), .data_writeReg(wData2),
        .ctrl_readRegA(rA2), .ctrl_readRegB(rB2),
        .data_readRegA(dA2), .data_readRegB(dB2),
        .ctrl_setBusy(set2), .ctrl_busyReg(bReg2),
        .busy_readRegA(bA2), .busy_readRegB(bB2)
    );

    task automatic checkVal(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic pushExp(input string tag, input int sel,
                           input logic [63:0] v);
        expEntry e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            0: return {32'h0, dA0};
            1: return {32'h0, dB0};
            2: return {63'h0, bA0};
            3: return {63'h0, bB0};
            4: return {32'h0, dA1};
            5: return {63'h0, bA1};
            6: return dA2;
            7: return dB2;
            8: return {63'h0, bA2};
            default: return 64'hX;
        endcase
    endfunction

    task automatic sampleAll();
        expEntry e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkVal(e.tag, actual(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wEn = 0; setB = 0; be = 4'hF;
        w2En = 0; set2 = 0; be2 = 8'hFF;
    endtask

    logic [63:0] v2 [8];

    initial begin
        rst = 1; idle();
        wReg = 0; wData = 0; rA = 0; rB = 0; bReg = 0;
        w2Reg = 0; wData2 = 0; rA2 = 0; rB2 = 0; bReg2 = 0;
        tick(); tick();
        rst = 0;

        rA = 3; rB = 0; rA2 = 5;
        pushExp("rst_dA", 0, 0); pushExp("rst_dB", 1, 0);
        pushExp("rst_bA", 2, 0); pushExp("rst_bB", 3, 0);
        pushExp("rst_dA_nb", 4, 0); pushExp("rst_bA_nb", 5, 0);
        pushExp("rst_dA64", 6, 0); pushExp("rst_bA64", 8, 0);
        sampleAll();

        for (int r = 0; r < 32; r++) begin
            wEn = 1; wReg = 5'(r); wData = 32'h0000DEAD; be = 4'hF;
            tick();
            wEn = 0; rA = 5'(r); rB = 5'(r);
            pushExp("fill_dA", 0, (r == 0) ? 0 : 64'hDEAD);
            pushExp("fill_dB", 1, (r == 0) ? 0 : 64'hDEAD);
            pushExp("fill_dA_nb", 4, (r == 0) ? 0 : 64'hDEAD);
            sampleAll();
        end

        wEn = 1; wReg = 5; wData = 32'h11223344; be = 4'hF; tick();
        wData = 32'hAABBCCDD; be = 4'b0101; tick();
        idle(); rA = 5; rB = 5;
        pushExp("byteen_dA", 0, 64'h11BB33DD);
        pushExp("byteen_dB", 1, 64'h11BB33DD);
        sampleAll();

        wEn = 1; wReg = 7; wData = 32'h1; tick();
        wData = 32'h77; rA = 7;
        pushExp("byp_pre", 0, 64'h77);
        pushExp("nobyp_pre", 4, 64'h1);
        sampleAll();
        tick(); wEn = 0;
        pushExp("byp_post", 0, 64'h77);
        pushExp("nobyp_post", 4, 64'h77);
        sampleAll();
        wEn = 1; wData = 32'h12345678; be = 4'b0010;
        pushExp("bypbe_pre", 0, 64'h5677);
        pushExp("nobypbe_pre", 4, 64'h77);
        sampleAll();
        tick(); idle();
        pushExp("bypbe_post", 0, 64'h5677);
        pushExp("nobypbe_post", 4, 64'h5677);
        sampleAll();

        setB = 1; bReg = 9; tick();
        setB = 0; rA = 9;
        pushExp("set_bA", 2, 1); pushExp("set_bA_nb", 5, 1);
        sampleAll();
        wEn = 1; wReg = 9; wData = 32'h5; setB = 1; bReg = 9;
        pushExp("setwr_pre_bA", 2, 1); pushExp("setwr_pre_dA", 0, 5);
        pushExp("setwr_pre_dA_nb", 4, 64'hDEAD);
        pushExp("setwr_pre_bA_nb", 5, 1);
        sampleAll();
        tick(); idle();
        pushExp("setwr_bA", 2, 1); pushExp("setwr_dA", 0, 5);
        pushExp("setwr_bA_nb", 5, 1); pushExp("setwr_dA_nb", 4, 5);
        sampleAll();
        wEn = 1; wReg = 9; wData = 32'h6;
        pushExp("clr_pre_bA", 2, 0); pushExp("clr_pre_bA_nb", 5, 1);
        sampleAll();
        tick(); idle();
        pushExp("clr_bA", 2, 0); pushExp("clr_bA_nb", 5, 0);
        pushExp("clr_dA", 0, 6);
        sampleAll();

        setB = 1; bReg = 10; wEn = 1; wReg = 11; wData = 32'h42; tick();
        idle(); rA = 10; rB = 11;
        pushExp("diff_bA", 2, 1); pushExp("diff_bB", 3, 0);
        pushExp("diff_dB", 1, 64'h42);
        sampleAll();
        setB = 1; bReg = 10; tick(); idle();
        pushExp("reset_bA", 2, 1);
        sampleAll();

        setB = 1; bReg = 3; tick(); idle();
        wEn = 1; wReg = 4; wData = 32'hFF; tick(); idle();
        rA = 3; rB = 4;
        pushExp("pend_bA", 2, 1); pushExp("pend_dB", 1, 64'hFF);
        sampleAll();
        rst = 1; setB = 1; bReg = 4;
        wEn = 1; wReg = 5; wData = 32'hCAFE; rB = 5;
        pushExp("rstbyp_dB", 1, 64'h11BB33DD);
        sampleAll();
        tick(); rst = 0; idle(); rA = 3; rB = 4;
        pushExp("midrst_bA", 2, 0); pushExp("midrst_dA", 0, 0);
        pushExp("midrst_bB", 3, 0); pushExp("midrst_dB", 1, 0);
        sampleAll();
        rA = 10; rB = 5;
        pushExp("midrst_b10", 2, 0); pushExp("midrst_d5", 1, 0);
        sampleAll();
        wEn = 1; wReg = 3; wData = 32'h33; tick(); idle(); rA = 3;
        pushExp("late_dA", 0, 64'h33); pushExp("late_bA", 2, 0);
        sampleAll();

        setB = 1; bReg = 0; tick(); idle(); rA = 0;
        pushExp("r0_bA", 2, 0); pushExp("r0_dA", 0, 0);
        sampleAll();
        wEn = 1; wReg = 0; wData = 32'hFFFFFFFF;
        pushExp("r0_pre_dA", 0, 0);
        sampleAll();
        tick(); idle();
        pushExp("r0_post_dA", 0, 0);
        sampleAll();

        w2En = 1; w2Reg = 7; wData2 = 64'hFFFF0000FFFF0000; be2 = 8'h0F;
        tick(); idle(); rA2 = 7;
        pushExp("w64_be", 6, 64'h00000000FFFF0000);
        sampleAll();
        for (int r = 0; r < 8; r++) begin
            v2[r] = 64'h0123456789ABCDEF ^ (64'(r) * 64'h1111111111111111);
            w2En = 1; w2Reg = 3'(r); wData2 = v2[r]; be2 = 8'hFF;
            tick();
        end
        idle();
        for (int r = 0; r < 8; r++) begin
            rA2 = 3'(r); rB2 = 3'(7 - r);
            pushExp("w64_dA", 6, (r == 0) ? 0 : v2[r]);
            pushExp("w64_dB", 7, (r == 7) ? 0 : v2[7 - r]);
            sampleAll();
        end
        set2 = 1; bReg2 = 2; tick(); idle(); rA2 = 2;
        pushExp("w64_bA", 8, 1);
        sampleAll();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
